lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: the number of cycles in REQ plus RESP after which an access is abandoned.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 rmem  input  1  load request from the execute stage.
REQ-005 wmem  input  1  store request from the execute stage.
REQ-006 addr  input  32  byte address, i.e. the execute-stage result.
REQ-007 wdata  input  32  store data (rs2).
REQ-008 funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 stall  output  1  holds the upstream pipeline.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  one-cycle error pulse, asserted together with done.
REQ-012 load_data  output  32  extended load result, valid while done=1 and err=0 for a load.
REQ-013 bus_req  output  1  bus request.
REQ-014 bus_we  output  1  bus write.
REQ-015 bus_addr  output  32  bus address, word-aligned.
REQ-016 bus_be  output  4  bus byte enables.
REQ-017 bus_wdata  output  32  bus write data.
REQ-018 bus_gnt  input  1  bus grant.
REQ-019 bus_rvalid  input  1  bus response: read data or write acknowledge.
REQ-020 bus_rdata  input  32  bus read data.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, RESP, DONE.
REQ-022 In IDLE with rmem^wmem=1 and a legal, aligned access, the block SHALL capture the operands and go to REQ.
REQ-023 In IDLE with an illegal access (rmem&wmem, unlisted funct3, store funct3>010, H with addr[0]=1, W with addr[1:0]!=0), the block SHALL go to DONE with err=1 and issue no bus access.
REQ-024 stall SHALL equal (IDLE & (rmem|wmem)) | REQ | RESP, and SHALL be 0 in DONE.
REQ-025 In REQ, bus_req SHALL be 1 and the captured address/data/enables SHALL be held stable; on bus_gnt=1 the FSM SHALL go to RESP.
REQ-026 In RESP, on bus_rvalid=1 the FSM SHALL go to DONE and register bus_rdata.
REQ-027 In DONE, done SHALL be 1, no new request SHALL be accepted, and the next state SHALL be IDLE.
REQ-028 bus_addr SHALL equal {addr[31:2],2'b00}.
REQ-029 Byte store: bus_be SHALL be 1<<addr[1:0] and bus_wdata SHALL be the byte replicated x4.
REQ-030 Halfword store: bus_be SHALL be 0011 or 1100 by addr[1] and bus_wdata SHALL be the halfword replicated x2.
REQ-031 Word store: bus_be SHALL be 1111.
REQ-032 Loads: bus_be SHALL be computed as for stores, and bus_we SHALL be 0.
REQ-033 load_data SHALL select the byte or halfword by addr[1:0] and sign-extend it (B, H) or zero-extend it (BU, HU); W SHALL pass through.
REQ-034 Timeout: a counter SHALL clear when REQ is entered and increment each cycle in REQ or RESP; on reaching TIMEOUT the FSM SHALL go to DONE with err=1 and drop bus_req.
REQ-035 bus_rvalid SHALL be ignored outside RESP, and bus_gnt SHALL be ignored outside REQ.
REQ-036 A response SHALL NOT be accepted in the cycle the grant is taken, so minimum latency from request to done is 3 cycles: IDLE, REQ with gnt, RESP with rvalid, then DONE.
REQ-037 After a store, load_data SHALL be 0.

Reset
REQ-038 With rst_n=0 at a clock edge, the block SHALL go to IDLE and clear the counter; after that edge bus_req, done, err, stall (if rmem=wmem=0), and load_data SHALL all be 0.
REQ-039 Reset during REQ or RESP SHALL abandon the access with no done pulse, and a late bus_rvalid SHALL be ignored.

Verification
REQ-040 LB addr=0x1003, rdata=0x80FF_FFFF, gnt and rvalid immediate -> bus_addr=0x1000, be=1000, done on the 4th cycle, load_data=0xFFFF_FF80.
REQ-041 SH addr=0x2002, wdata=0x0000_BEEF -> bus_we=1, be=1100, bus_wdata=0xBEEF_BEEF, done after rvalid, err=0.
REQ-042 LW addr=0x0006 -> no bus_req; done=err=1 in the cycle after the request; stall high for exactly one cycle.
REQ-043 LHU addr=0x0,…, gnt withheld for TIMEOUT cycles -> bus_req drops, done=err=1.
REQ-044 rst_n=0 in RESP, then rvalid=1 -> no done, FSM in IDLE, bus_req=0.
REQ-045 Back-to-back LW then SW with rmem/wmem held until stall=0 -> two distinct bus transactions, one done pulse each, and no re-issue during DONE.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns one execute-stage load or store into a single
// word-aligned bus access and returns the sized, extended load result.
// Ports: clk/rst_n; rmem/wmem/addr/wdata/funct3 from execute; stall/done/err/
//        load_data back to the pipeline; bus_req/we/addr/be/wdata out,
//        bus_gnt/rvalid/rdata in. Minimum request-to-done is 3 cycles.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rmem,
  input  logic        wmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Access decode: legality, byte enables and lane-replicated store data.
  logic        legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  always_comb begin
    legal     = 1'b0;
    be_new    = 4'b0000;
    wdata_new = wdata;
    case (funct3)
      3'b000, 3'b100: begin
        // Unsigned variants exist only for loads.
        legal     = !(wmem && funct3[2]);
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        legal     = !addr[0] && !(wmem && funct3[2]);
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
      3'b010: begin
        legal     = (addr[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
      default: legal = 1'b0;
    endcase
    if (rmem && wmem) legal = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    f3_d    = f3_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rmem || wmem) begin
          we_d  = wmem;
          err_d = !legal;
          if (legal) begin
            addr_d  = addr;
            wdata_d = wdata_new;
            be_d    = be_new;
            f3_d    = funct3;
            state_d = REQ;
          end else begin
            // Illegal access completes immediately without touching the bus.
            state_d = DONE;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A grant on the final budgeted cycle leaves no room for a response,
        // so the timeout wins.
        if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load result extraction from the registered response.
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_b = rdata_q[7:0];
      2'b01:   ld_b = rdata_q[15:8];
      2'b10:   ld_b = rdata_q[23:16];
      default: ld_b = rdata_q[31:24];
    endcase
    ld_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {24'h0, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = rdata_q;
    endcase
  end

  assign stall     = ((state_q == IDLE) && (rmem || wmem)) ||
                     (state_q == REQ) || (state_q == RESP);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign load_data = ((state_q == DONE) && !err_q && !we_q) ? ld_ext : 32'h0;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = (state_q == REQ) && we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rmem, wmem;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic        stall, done, err;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rmem(rmem), .wmem(wmem), .addr(addr),
    .wdata(wdata), .funct3(funct3), .stall(stall), .done(done), .err(err),
    .load_data(load_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        err;
    logic [31:0] ld;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   m_be = 4'b0001 << a[1:0];
      2'b01:   m_be = a[1] ? 4'b1100 : 4'b0011;
      default: m_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   m_wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   m_wd = {d[15:0], d[15:0]};
      default: m_wd = d;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (8 * a[1:0]));
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  m_ld = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100:  m_ld = {24'h0, b};
      3'b001:  m_ld = h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101:  m_ld = {16'h0, h};
      default: m_ld = rd;
    endcase
  endfunction

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("done_err", {31'b0, err}, {31'b0, e.err});
        chk("load_data", load_data, e.ld);
      end
    end else if (err) begin
      chk("err_without_done", 32'd1, 32'd0);
    end
  end

  // Presents one access (held until stall drops) and plays the bus slave.
  task automatic access(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gdly, input int rdly,
                        input logic e_err, input int e_stall, input int e_req,
                        input logic noisy);
    exp_t e;
    int   nstall = 0;
    int   nreq = 0;
    int   rcnt = 0;
    logic in_resp = 1'b0;
    logic fin = 1'b0;
    e.err = e_err;
    e.ld  = (e_err || w) ? 32'h0 : m_ld(f3, a, rd);
    sb_q.push_back(e);
    @(posedge clk); #1;
    rmem = r; wmem = w; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 4 * TO + 20 && !fin; c++) begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hDEAD_BEEF;
      if (!stall) fin = 1'b1;
      else begin
        nstall++;
        if (bus_req) begin
          nreq++;
          chk("bus_addr", bus_addr, {a[31:2], 2'b00});
          chk("bus_be", {28'b0, bus_be}, {28'b0, m_be(f3, a)});
          chk("bus_we", {31'b0, bus_we}, {31'b0, w});
          if (w) chk("bus_wdata", bus_wdata, m_wd(f3, wd));
          if (noisy) begin bus_rvalid = 1'b1; bus_rdata = ~rd; end
          if (nreq - 1 == gdly) begin bus_gnt = 1'b1; in_resp = 1'b1; end
        end else if (in_resp) begin
          if (noisy) bus_gnt = 1'b1;
          if (rcnt == rdly) begin bus_rvalid = 1'b1; bus_rdata = rd; end
          rcnt++;
        end
      end
    end
    if (!fin) chk("wait_done", 32'd0, 32'd1);
    chk("stall_cycles", nstall, e_stall);
    chk("req_cycles", nreq, e_req);
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    rmem = 1'b0; wmem = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rmem = 1'b0; wmem = 1'b0; addr = '0; wdata = '0; funct3 = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // r, w, f3, addr, wdata, rdata, gdly, rdly, err, stall, req, noisy
    access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 3, 1, 0);
    idle_in();
    access(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1, 2, 0, 6, 2, 1);
    idle_in();
    access(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0);
    idle_in();
    access(1, 0, 3'b101, 32'h0000_0000, 32'h0, 32'h0, 1000, 0, 1, 1 + TO, TO, 0);
    idle_in();
    // Back-to-back: request held through DONE must not be re-issued.
    access(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h1234_5678, 0, 1, 0, 4, 1, 0);
    access(0, 1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 2, 0, 0, 5, 3, 0);
    idle_in();
    access(1, 0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 0, 0, 0, 3, 1, 0);
    access(1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 0, 0, 0, 3, 1, 0);
    access(1, 0, 3'b100, 32'h0000_5001, 32'h0, 32'h0000_A500, 0, 0, 0, 3, 1, 0);
    access(1, 0, 3'b000, 32'h0000_5001, 32'h0, 32'h0000_A500, 0, 0, 0, 3, 1, 0);
    access(0, 1, 3'b000, 32'h0000_6001, 32'h1234_56AB, 32'h0, 0, 0, 0, 3, 1, 0);
    idle_in();
    access(1, 1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0);
    idle_in();
    access(1, 0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0);
    idle_in();
    access(0, 1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0);
    idle_in();
    access(1, 0, 3'b001, 32'h0000_4001, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0);
    idle_in();
    access(1, 0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 0, 1000, 1, 1 + TO, 1, 0);
    idle_in();

    // Reset while waiting for the response; a late rvalid must be ignored.
    @(posedge clk); #1;
    rmem = 1'b1; funct3 = 3'b010; addr = 32'h0000_7000;
    @(negedge clk);
    @(negedge clk);
    chk("rr_bus_req", {31'b0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rr_resp_stall", {31'b0, stall}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1; rmem = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    chk("rr_done", {31'b0, done}, 32'd0);
    chk("rr_bus_req_after", {31'b0, bus_req}, 32'd0);
    chk("rr_stall_after", {31'b0, stall}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rr_late_rvalid", {31'b0, done}, 32'd0);
    chk("rr_stall_idle", {31'b0, stall}, 32'd0);
    bus_rvalid = 1'b0;
    // Fresh access after reset proves the FSM came back to IDLE.
    access(1, 0, 3'b010, 32'h0000_7000, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 3, 1, 0);
    idle_in();
    repeat (3) @(negedge clk);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
